// File: rtl/aes_io_pkg.sv
// Shared definitions for the AES byte-stream input and output stages.
// Block geometry and the assembler/disassembler state encoding.
package aes_io_pkg;

    localparam int BLOCK_BYTES = 16;
    localparam int BLOCK_W     = 8 * BLOCK_BYTES;
    localparam int CNT_W       = $clog2(BLOCK_BYTES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        FULL = 2'd2
    } state_e;

    // Byte i of a block sits at bits [8i+7:8i].
    function automatic logic [7:0] block_byte(
        input logic [BLOCK_W-1:0] blk,
        input int unsigned        idx
    );
        return blk[8*idx +: 8];
    endfunction

endpackage

// File: rtl/byte_gap_timer.sv
// Idle-gap watchdog for a partially assembled block.
// expire fires on the enabled cycle in which the gap reaches its limit.
module byte_gap_timer #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    if (TIMEOUT_CYCLES == 0) begin : g_off
        logic unused_in;
        assign unused_in = clear ^ enable;
        assign expire    = 1'b0;
    end else begin : g_on
        localparam int W = $clog2(TIMEOUT_CYCLES + 1);
        localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

        logic [W-1:0] gap_q;
        logic [W-1:0] gap_d;

        assign expire = enable & ~clear & (gap_q == LAST);

        always_comb begin
            gap_d = gap_q;
            if (clear || expire) begin
                gap_d = '0;
            end else if (enable) begin
                gap_d = gap_q + W'(1);
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                gap_q <= '0;
            end else begin
                gap_q <= gap_d;
            end
        end
    end

endmodule

// File: rtl/read_plain.sv
// Byte-serial to 128-bit block assembler feeding the AES encrypt core.
// First byte lands in the MSB; the block is held until plain_ready.
module read_plain
    import aes_io_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [7:0]         byte_in,
    input  logic               byte_valid,
    output logic               byte_ready,
    input  logic               flush,
    output logic [BLOCK_W-1:0] plain_out,
    output logic               plain_valid,
    input  logic               plain_ready,
    output logic               timeout_err
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLOCK_BYTES - 1);

    state_e             state_q;
    state_e             state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic [BLOCK_W-1:0] shift_q;
    logic [BLOCK_W-1:0] shift_d;
    logic               terr_q;
    logic               terr_d;

    logic byte_xfer;
    logic blk_xfer;
    logic gap_en;
    logic gap_clr;
    logic expire;

    // A full block only makes room when the consumer is taking it.
    assign byte_ready  = (state_q == FULL) ? plain_ready : 1'b1;
    assign plain_valid = (state_q == FULL);
    assign plain_out   = shift_q;
    assign timeout_err = terr_q;

    assign byte_xfer = byte_valid & byte_ready & ~flush;
    assign blk_xfer  = plain_valid & plain_ready;
    assign gap_en    = (state_q == FILL) & ~byte_xfer & ~flush;
    assign gap_clr   = byte_xfer | flush | (state_q != FILL);

    byte_gap_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_gap (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (gap_clr),
        .enable(gap_en),
        .expire(expire)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        terr_d  = 1'b0;

        if (flush) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            if (byte_xfer) begin
                shift_d = {shift_q[BLOCK_W-9:0], byte_in};
                cnt_d   = cnt_q + CNT_W'(1);
            end

            unique case (state_q)
                IDLE: begin
                    if (byte_xfer) begin
                        state_d = FILL;
                    end
                end
                FILL: begin
                    if (byte_xfer && cnt_q == CNT_LAST) begin
                        state_d = FULL;
                    end else if (expire) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        terr_d  = 1'b1;
                    end
                end
                FULL: begin
                    // A byte taken alongside the block starts the next one.
                    if (blk_xfer) begin
                        state_d = byte_xfer ? FILL : IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            terr_q  <= terr_d;
        end
    end

endmodule

// File: tb/tb_read_plain.sv
// Self-checking bench for read_plain against a queue-based block model.
// Directed vectors, corner sequences and randomized traffic.
module tb_read_plain;

    localparam int T = 8;

    logic         clk;
    logic         rst_n;
    logic [7:0]   byte_in;
    logic         byte_valid;
    logic         byte_ready;
    logic         flush;
    logic [127:0] plain_out;
    logic         plain_valid;
    logic         plain_ready;
    logic         timeout_err;

    read_plain #(.TIMEOUT_CYCLES(T)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .flush      (flush),
        .plain_out  (plain_out),
        .plain_valid(plain_valid),
        .plain_ready(plain_ready),
        .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Model: bytes of the partial block, and the held block if any.
    logic [7:0]   m_q[$];
    logic         m_held;
    logic [127:0] m_blk;
    int           m_gap;
    logic         m_terr;

    typedef struct {
        logic         bv;
        logic [7:0]   b;
        logic         pr;
        logic         fl;
        logic         exp_ready;
        logic         exp_valid;
        logic         exp_terr;
    } vec_t;

    vec_t vecs[17];

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] pack16();
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) r[127-8*i -: 8] = m_q[i];
        return r;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_held = 1'b0;
        m_blk  = '0;
        m_gap  = 0;
        m_terr = 1'b0;
    endtask

    task automatic model_step(input logic bv, input logic [7:0] b,
                              input logic pr, input logic fl);
        logic rdy;
        rdy = m_held ? pr : 1'b1;
        m_terr = 1'b0;
        if (fl) begin
            m_q.delete();
            m_held = 1'b0;
            m_gap  = 0;
        end else if (m_held) begin
            if (pr) begin
                m_held = 1'b0;
                if (bv) m_q.push_back(b);
            end
            m_gap = 0;
        end else if (bv && rdy) begin
            m_q.push_back(b);
            m_gap = 0;
            if (m_q.size() == 16) begin
                m_blk  = pack16();
                m_held = 1'b1;
                m_q.delete();
            end
        end else if (m_q.size() > 0) begin
            if (m_gap == T - 1) begin
                m_q.delete();
                m_gap  = 0;
                m_terr = 1'b1;
            end else begin
                m_gap++;
            end
        end
    endtask

    // Apply inputs for one cycle; checks ready before and outputs after edge.
    task automatic tick(input logic bv, input logic [7:0] b,
                        input logic pr, input logic fl);
        byte_valid  = bv;
        byte_in     = b;
        plain_ready = pr;
        flush       = fl;
        #1;
        chk("byte_ready", 128'(byte_ready), 128'(m_held ? pr : 1'b1));
        @(posedge clk);
        model_step(bv, b, pr, fl);
        #1;
        chk("plain_valid", 128'(plain_valid), 128'(m_held));
        chk("timeout_err", 128'(timeout_err), 128'(m_terr));
        if (m_held) chk("plain_out", plain_out, m_blk);
    endtask

    task automatic idle(input logic pr);
        tick(1'b0, 8'h00, pr, 1'b0);
    endtask

    task automatic send_block(input logic [7:0] base);
        for (int i = 0; i < 16; i++) tick(1'b1, base + 8'(i), 1'b1, 1'b0);
    endtask

    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_valid", 128'(plain_valid), 128'd0);
        chk("rst_terr", 128'(timeout_err), 128'd0);
        chk("rst_out", plain_out, 128'd0);
        chk("rst_ready", 128'(byte_ready), 128'd1);
        byte_valid = 1'b0;
        flush      = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    logic [127:0] fips;
    int first_v;
    int second_v;
    int seen;

    initial begin
        fips = 128'h00112233445566778899aabbccddeeff;
        for (int i = 0; i < 16; i++) begin
            vecs[i] = '{1'b1, 8'(i * 17), 1'b1, 1'b0, 1'b1, i == 15, 1'b0};
        end
        vecs[16] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

        rst_n = 1'b0;
        byte_valid = 1'b0;
        byte_in = 8'h00;
        flush = 1'b0;
        plain_ready = 1'b0;
        model_reset();
        #2;
        chk("reset_valid", 128'(plain_valid), 128'd0);
        chk("reset_out", plain_out, 128'd0);
        chk("reset_terr", 128'(timeout_err), 128'd0);
        chk("reset_ready", 128'(byte_ready), 128'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // FIPS-197 plaintext, consumer always ready
        for (int i = 0; i < 17; i++) begin
            tick(vecs[i].bv, vecs[i].b, vecs[i].pr, vecs[i].fl);
            chk("vec_valid", 128'(plain_valid), 128'(vecs[i].exp_valid));
            chk("vec_terr", 128'(timeout_err), 128'(vecs[i].exp_terr));
            if (i == 15) chk("vec_fips", plain_out, fips);
        end

        // Backpressure: block held, extra bytes refused
        for (int i = 0; i < 16; i++) tick(1'b1, 8'(i * 17), 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) begin
            tick(1'b1, 8'hee, 1'b0, 1'b0);
            chk("bp_out", plain_out, fips);
            chk("bp_ready", 128'(byte_ready), 128'd0);
        end
        tick(1'b1, 8'h5a, 1'b1, 1'b0);
        chk("bp_taken", 128'(plain_valid), 128'd0);
        for (int i = 1; i < 16; i++) tick(1'b1, 8'(i), 1'b1, 1'b0);
        chk("bp_next", plain_out, 128'h5a0102030405060708090a0b0c0d0e0f);
        idle(1'b1);

        // Back-to-back blocks
        first_v = -1;
        second_v = -1;
        for (int i = 0; i < 33; i++) begin
            if (i < 32) tick(1'b1, 8'(8'h80 + i), 1'b1, 1'b0);
            else idle(1'b1);
            if (plain_valid) begin
                if (first_v < 0) first_v = i;
                else second_v = i;
            end
        end
        chk("b2b_first", 128'(first_v), 128'd15);
        chk("b2b_period", 128'(second_v - first_v), 128'd16);

        // Timeout after 5 bytes
        for (int i = 0; i < 5; i++) tick(1'b1, 8'hc0 + 8'(i), 1'b1, 1'b0);
        seen = -1;
        for (int k = 1; k <= 20 && seen < 0; k++) begin
            idle(1'b1);
            if (timeout_err) seen = k;
        end
        chk("timeout_delay", 128'(seen), 128'(T));
        send_block(8'h30);
        chk("timeout_fresh", plain_out, 128'h303132333435363738393a3b3c3d3e3f);
        idle(1'b1);

        // Flush mid-fill and while full
        for (int i = 0; i < 7; i++) tick(1'b1, 8'h11, 1'b1, 1'b0);
        tick(1'b1, 8'h22, 1'b1, 1'b1);
        for (int i = 0; i < T + 2; i++) begin
            idle(1'b1);
            chk("flush_noterr", 128'(timeout_err), 128'd0);
        end
        for (int i = 0; i < 16; i++) tick(1'b1, 8'h40 + 8'(i), 1'b0, 1'b0);
        tick(1'b1, 8'h99, 1'b1, 1'b1);
        chk("flush_full", 128'(plain_valid), 128'd0);
        send_block(8'h60);
        chk("flush_after", plain_out, 128'h606162636465666768696a6b6c6d6e6f);
        idle(1'b1);

        // Asynchronous reset mid-block
        for (int i = 0; i < 9; i++) tick(1'b1, 8'h77, 1'b1, 1'b0);
        async_reset();
        send_block(8'ha0);
        chk("rst_after", plain_out, 128'ha0a1a2a3a4a5a6a7a8a9aaabacadaeaf);
        idle(1'b1);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            logic bv, pr, fl;
            int mode;
            mode = (n / 300) % 3;
            bv = (mode == 2) ? ($urandom_range(0, 9) < 2)
                             : ($urandom_range(0, 9) < 8);
            pr = (mode == 1) ? ($urandom_range(0, 9) < 3)
                             : ($urandom_range(0, 9) < 7);
            fl = ($urandom_range(0, 199) == 0);
            tick(bv, 8'($urandom), pr, fl);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: sim time expired, bench did not finish");
        $fatal(1);
    end

endmodule
